lab_cu_pro: RTL and testbench

//  Control unit that sequences the 8-bit accumulator datapath (IR, 5-bit PC, A, RAM).

---
 rtl/lab_cu_pro_pkg.sv | 46 ++++
 rtl/lab_cu_pro_decode.sv | 86 ++++++++
 rtl/lab_cu_pro.sv | 76 +++++++
 tb/tb_lab_cu_pro.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab_cu_pro_pkg.sv
// Shared definitions for the accumulator-machine control unit: opcodes,
// state codes, A-input select codes and the control word bundle.
package lab_cu_pro_pkg;

    localparam int OPW_DEF   = 3;
    localparam int CNT_W_DEF = 8;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'd0;
    localparam logic [1:0] ASEL_IN  = 2'd1;
    localparam logic [1:0] ASEL_MEM = 2'd2;

    // Code 3'd7 is deliberately unused; it decodes to IDLE with all controls low.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOADIR = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_INWAIT = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic       irload;
        logic       pcload;
        logic       jmpmux;
        logic       meminst;
        logic       memwr;
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       in_ready;
        logic       halted;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/lab_cu_pro_decode.sv
// Combinational heart of the control unit: from the current state, opcode,
// accumulator flags and input handshake, produce the control word and next state.
module lab_cu_pro_decode
    import lab_cu_pro_pkg::*;
(
    input  state_e           state_i,
    input  logic             start_i,
    input  logic [OPW_DEF-1:0] ir75_i,
    input  logic             aeq0_i,
    input  logic             apos_i,
    input  logic             in_valid_i,
    output ctrl_t            ctrl_o,
    output state_e           state_d_o
);

    always_comb begin
        state_d_o = ST_IDLE;
        case (state_i)
            ST_IDLE:   state_d_o = start_i ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_d_o = ST_LOADIR;
            ST_LOADIR: state_d_o = ST_DECODE;
            ST_DECODE: begin
                case (ir75_i)
                    OP_LOAD, OP_ADD, OP_SUB: state_d_o = ST_EXEC;
                    OP_INPUT:                state_d_o = ST_INWAIT;
                    OP_HALT:                 state_d_o = ST_HALT;
                    default:                 state_d_o = ST_FETCH;
                endcase
            end
            ST_EXEC:   state_d_o = ST_FETCH;
            ST_INWAIT: state_d_o = in_valid_i ? ST_FETCH : ST_INWAIT;
            ST_HALT:   state_d_o = ST_HALT;
            default:   state_d_o = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_LOADIR: begin
                ctrl_o.irload = 1'b1;
                ctrl_o.pcload = 1'b1;
            end
            ST_DECODE: begin
                case (ir75_i)
                    OP_LOAD, OP_ADD, OP_SUB: ctrl_o.meminst = 1'b1;
                    OP_STORE: begin
                        ctrl_o.meminst = 1'b1;
                        ctrl_o.memwr   = 1'b1;
                        ctrl_o.retire  = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl_o.jmpmux = aeq0_i;
                        ctrl_o.pcload = aeq0_i;
                        ctrl_o.retire = 1'b1;
                    end
                    OP_JPOS: begin
                        ctrl_o.jmpmux = apos_i;
                        ctrl_o.pcload = apos_i;
                        ctrl_o.retire = 1'b1;
                    end
                    OP_HALT: ctrl_o.retire = 1'b1;
                    default: ctrl_o = '0;
                endcase
            end
            ST_EXEC: begin
                ctrl_o.meminst = 1'b1;
                ctrl_o.aload   = 1'b1;
                ctrl_o.retire  = 1'b1;
                ctrl_o.asel    = (ir75_i == OP_LOAD) ? ASEL_MEM : ASEL_ALU;
                ctrl_o.sub     = (ir75_i == OP_SUB);
            end
            ST_INWAIT: begin
                ctrl_o.in_ready = 1'b1;
                if (in_valid_i) begin
                    ctrl_o.asel   = ASEL_IN;
                    ctrl_o.aload  = 1'b1;
                    ctrl_o.retire = 1'b1;
                end
            end
            ST_HALT: ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/lab_cu_pro.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Holds the state register and the retired-instruction counter only.
module lab_cu_pro
    import lab_cu_pro_pkg::*;
#(
    parameter int OPW   = OPW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   IR75,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             in_valid,
    output logic             IRload,
    output logic             PCload,
    output logic             JMPmux,
    output logic             Meminst,
    output logic             MemWr,
    output logic [1:0]       Asel,
    output logic             Aload,
    output logic             Sub,
    output logic             in_ready,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] icount,
    output logic [2:0]       dbg_state_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    ctrl_t            ctrl;

    lab_cu_pro_decode u_decode (
        .state_i    (state_q),
        .start_i    (start),
        .ir75_i     (IR75),
        .aeq0_i     (Aeq0),
        .apos_i     (Apos),
        .in_valid_i (in_valid),
        .ctrl_o     (ctrl),
        .state_d_o  (state_d)
    );

    // Counter wraps naturally at 2^CNT_W.
    always_comb begin
        icount_d = icount_q;
        if (ctrl.retire) icount_d = icount_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    assign IRload      = ctrl.irload;
    assign PCload      = ctrl.pcload;
    assign JMPmux      = ctrl.jmpmux;
    assign Meminst     = ctrl.meminst;
    assign MemWr       = ctrl.memwr;
    assign Asel        = ctrl.asel;
    assign Aload       = ctrl.aload;
    assign Sub         = ctrl.sub;
    assign in_ready    = ctrl.in_ready;
    assign halted      = ctrl.halted;
    assign instr_done  = ctrl.retire;
    assign icount      = icount_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lab_cu_pro.sv
// Bench for lab_cu_pro: a small behavioural accumulator datapath with a
// synchronous-read RAM, single-instruction vector table and program sequences.
module tb_lab_cu_pro;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] IR75;
    logic       Aeq0, Apos;
    logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub;
    logic [1:0] Asel;
    logic       in_ready, halted, instr_done;
    logic [7:0] icount;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    lab_cu_pro dut (
        .clock(clock), .reset(reset), .start(start), .IR75(IR75),
        .Aeq0(Aeq0), .Apos(Apos), .in_valid(in_valid),
        .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
        .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub),
        .in_ready(in_ready), .halted(halted), .instr_done(instr_done),
        .icount(icount), .dbg_state_o(dbg_state)
    );

    // Datapath model
    logic [7:0] dp_ram [32];
    logic [7:0] img    [32];
    logic [7:0] dp_a, dp_q, dp_ir, a_init, in_data;
    logic [4:0] dp_pc, dp_addr;
    logic       dp_clr = 1'b0;
    logic [7:0] a_next;

    assign IR75    = dp_ir[7:5];
    assign Aeq0    = (dp_a == 8'h00);
    assign Apos    = ~dp_a[7];
    assign dp_addr = Meminst ? dp_ir[4:0] : dp_pc;

    always_comb begin
        a_next = dp_a;
        case (Asel)
            2'd0:    a_next = Sub ? dp_a - dp_q : dp_a + dp_q;
            2'd1:    a_next = in_data;
            2'd2:    a_next = dp_q;
            default: a_next = dp_a;
        endcase
    end

    always @(posedge clock) begin
        if (dp_clr) begin
            dp_pc  <= 5'd0;
            dp_ir  <= 8'd0;
            dp_q   <= 8'd0;
            dp_a   <= a_init;
            dp_ram <= img;
        end else begin
            dp_q <= dp_ram[dp_addr];
            if (MemWr)  dp_ram[dp_addr] <= dp_a;
            if (IRload) dp_ir <= dp_q;
            if (PCload) dp_pc <= JMPmux ? dp_ir[4:0] : dp_pc + 5'd1;
            if (Aload)  dp_a <= a_next;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'hE0;
    endtask

    task automatic start_run();
        @(negedge clock);
        reset = 1'b0; start = 1'b0; dp_clr = 1'b1;
        @(negedge clock);
        dp_clr = 1'b0; reset = 1'b1; start = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Returns at the falling edge of the cycle in which instr_done is high.
    task automatic run_until_done(input int budget, output int cyc);
        bit seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (instr_done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout: no instr_done within %0d cycles", budget);
        end
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [7:0] a;
        logic [7:0] m;
        logic [7:0] din;
        int         cyc;
        logic [7:0] exp_a;
        logic [4:0] exp_pc;
        logic [7:0] exp_m;
        logic       exp_jmp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int cyc, sum;
        int bad_spacing;

        //            instr  a      m      din    cyc a_exp  pc     m_exp  jmp
        vecs[0]  = '{8'h0A, 8'h33, 8'h05, 8'h99, 4, 8'h05, 5'd1, 8'h05, 1'b0};
        vecs[1]  = '{8'h2A, 8'h77, 8'h00, 8'h99, 3, 8'h77, 5'd1, 8'h77, 1'b0};
        vecs[2]  = '{8'h4A, 8'h10, 8'h22, 8'h99, 4, 8'h32, 5'd1, 8'h22, 1'b0};
        vecs[3]  = '{8'h4A, 8'hFF, 8'h02, 8'h99, 4, 8'h01, 5'd1, 8'h02, 1'b0};
        vecs[4]  = '{8'h6A, 8'h03, 8'h05, 8'h99, 4, 8'hFE, 5'd1, 8'h05, 1'b0};
        vecs[5]  = '{8'h6A, 8'h00, 8'h00, 8'h99, 4, 8'h00, 5'd1, 8'h00, 1'b0};
        vecs[6]  = '{8'h80, 8'h55, 8'h11, 8'h2A, 4, 8'h2A, 5'd1, 8'h11, 1'b0};
        vecs[7]  = '{8'hA7, 8'h00, 8'h11, 8'h99, 3, 8'h00, 5'd7, 8'h11, 1'b1};
        vecs[8]  = '{8'hA7, 8'h01, 8'h11, 8'h99, 3, 8'h01, 5'd1, 8'h11, 1'b0};
        vecs[9]  = '{8'hC9, 8'h05, 8'h11, 8'h99, 3, 8'h05, 5'd9, 8'h11, 1'b1};
        vecs[10] = '{8'hC9, 8'h80, 8'h11, 8'h99, 3, 8'h80, 5'd1, 8'h11, 1'b0};
        vecs[11] = '{8'hC9, 8'h00, 8'h11, 8'h99, 3, 8'h00, 5'd9, 8'h11, 1'b1};
        vecs[12] = '{8'hE0, 8'h44, 8'h11, 8'h99, 3, 8'h44, 5'd1, 8'h11, 1'b0};

        a_init = 8'h00;
        in_data = 8'h00;
        clear_img();

        // Reset state
        #3;
        check("reset_outputs",
              {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, in_ready, halted, instr_done},
              12'h000);
        check("reset_icount", icount, 8'd0);
        check("reset_state", dbg_state, 3'd0);

        // Single-instruction vectors; in_valid held high to show it is ignored outside INWAIT
        for (int v = 0; v < 13; v++) begin
            clear_img();
            img[0]  = vecs[v].instr;
            img[10] = vecs[v].m;
            a_init  = vecs[v].a;
            in_data = vecs[v].din;
            in_valid = 1'b1;
            start_run();
            run_until_done(20, cyc);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
            check($sformatf("v%0d_jump", v), PCload & JMPmux, vecs[v].exp_jmp);
            @(negedge clock);
            check($sformatf("v%0d_A", v), dp_a, vecs[v].exp_a);
            check($sformatf("v%0d_PC", v), dp_pc, vecs[v].exp_pc);
            check($sformatf("v%0d_M10", v), dp_ram[10], vecs[v].exp_m);
            check($sformatf("v%0d_icount", v), icount, 8'd1);
        end
        in_valid = 1'b0;

        // LOAD 10; ADD 11; STORE 12; HALT
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h4B; img[2] = 8'h2C; img[3] = 8'hE0;
        img[10] = 8'd5; img[11] = 8'd7; img[12] = 8'h00;
        a_init = 8'h00;
        start_run();
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            run_until_done(20, cyc);
            sum += cyc;
        end
        check("prog1_cycles", sum, 14);
        @(negedge clock);
        check("prog1_M12", dp_ram[12], 8'd12);
        check("prog1_halted", halted, 1'b1);
        check("prog1_icount", icount, 8'd4);
        repeat (5) @(negedge clock);
        check("prog1_still_halted", {halted, instr_done, icount}, {1'b1, 1'b0, 8'd4});

        // LOAD 10; SUB 11; JPOS 0 (not taken); HALT
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h6B; img[2] = 8'hC0; img[3] = 8'hE0;
        img[10] = 8'd3; img[11] = 8'd5;
        start_run();
        run_until_done(20, cyc);
        run_until_done(20, cyc);
        @(negedge clock);
        check("prog2_A", dp_a, 8'hFE);
        check("prog2_Apos", Apos, 1'b0);
        run_until_done(20, cyc);
        check("prog2_jpos_pcload", PCload, 1'b0);
        @(negedge clock);
        check("prog2_PC", dp_pc, 5'd3);
        run_until_done(20, cyc);
        @(negedge clock);
        check("prog2_halted", halted, 1'b1);

        // INPUT with in_valid held low, then released
        clear_img();
        img[0] = 8'h80;
        a_init = 8'h55;
        in_valid = 1'b0;
        in_data = 8'h77;
        start_run();
        repeat (3) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("inwait_%0d", k), {in_ready, instr_done, Aload, dp_a}, {3'b100, 8'h55});
        end
        in_data = 8'h2A;
        in_valid = 1'b1;
        #1;
        check("inwait_accept", {instr_done, Aload, Asel}, {2'b11, 2'd1});
        @(negedge clock);
        in_valid = 1'b0;
        check("inwait_after", {instr_done, in_ready, dp_a}, {2'b00, 8'h2A});
        check("inwait_icount", icount, 8'd1);

        // Asynchronous reset during EXEC of ADD
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h4B; img[10] = 8'd4; img[11] = 8'd3;
        a_init = 8'h00;
        start_run();
        run_until_done(20, cyc);
        repeat (4) @(negedge clock);
        check("exec_before_reset", {Aload, Asel, Sub, dbg_state, icount}, {1'b1, 2'd0, 1'b0, 3'd4, 8'd1});
        #2 reset = 1'b0;
        #1;
        check("exec_reset_async", {Aload, Meminst, instr_done, dbg_state, icount}, {3'b000, 3'd0, 8'd0});
        @(negedge clock);
        check("exec_reset_A", dp_a, 8'd4);

        // JZ to self with A=0: 256 retirements, icount wraps
        clear_img();
        img[0] = 8'hA0;
        a_init = 8'h00;
        start_run();
        bad_spacing = 0;
        for (int k = 1; k <= 256; k++) begin
            run_until_done(10, cyc);
            if (cyc != 3 || icount != 8'(k - 1)) bad_spacing++;
        end
        check("loop_spacing_count", bad_spacing, 0);
        check("loop_icount_255", icount, 8'd255);
        @(negedge clock);
        check("loop_icount_wrap", icount, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
